// File: rtl/soc_ifc_pkg.sv
// soc_ifc_pkg: shared fuse-loader state encoding and default register addresses
package soc_ifc_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, DONE_WR, DONE, ERROR} fuse_ld_state_e;
  localparam logic [31:0] FUSE_BASE_ADDR_DEFAULT = 32'h200;
  localparam logic [31:0] FUSE_DONE_ADDR_DEFAULT = 32'h3F8;
endpackage

// File: rtl/soc_ifc_hs_timeout.sv
// soc_ifc_hs_timeout: per-handshake wait counter that flags expiry on the last allowed cycle
module soc_ifc_hs_timeout #(
  parameter int LIMIT = 255,
  localparam int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic cptra_rst_b,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge cptra_rst_b)
    if (!cptra_rst_b) cnt <= '0;
    else cnt <= clr ? '0 : inc ? cnt + CNT_W'(1) : cnt;
  assign expire = inc && cnt == CNT_W'(LIMIT - 1);
endmodule

// File: rtl/soc_ifc_fuse_loader.sv
// soc_ifc_fuse_loader: copies fuse words from a source port into the soc_ifc fuse window, then writes fuse_done
module soc_ifc_fuse_loader
  import soc_ifc_pkg::*;
#(
  parameter int NUM_FUSE_WORDS = 32,
  parameter int ADDR_W = 18,
  parameter logic [31:0] FUSE_BASE_ADDR = FUSE_BASE_ADDR_DEFAULT,
  parameter logic [31:0] FUSE_DONE_ADDR = FUSE_DONE_ADDR_DEFAULT,
  parameter int ACK_TIMEOUT = 255,
  localparam int IDX_W = NUM_FUSE_WORDS > 1 ? $clog2(NUM_FUSE_WORDS) : 1,
  localparam int ERR_W = $clog2(NUM_FUSE_WORDS + 1)
) (
  input  logic              clk,
  input  logic              cptra_rst_b,
  input  logic              ready_for_fuses,
  output logic              src_req,
  output logic [IDX_W-1:0]  src_idx,
  input  logic              src_ack,
  input  logic [31:0]       src_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ack,
  input  logic              wr_err,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ERR_W-1:0]  err_idx
);
  fuse_ld_state_e state, state_n;
  logic gap;
  logic [IDX_W-1:0] idx, idx_n;
  logic [31:0] data, data_n;
  logic [ERR_W-1:0] err_n;
  logic req, ack, expire, hs_err, last;
  if (64'(FUSE_BASE_ADDR) + 64'(4 * (NUM_FUSE_WORDS - 1)) >= (64'd1 << ADDR_W)) begin : g_addr_range
    $error("fuse window does not fit in ADDR_W");
  end
  assign src_req = state == FETCH && !gap;
  assign wr_req = (state == WRITE || state == DONE_WR) && !gap;
  assign src_idx = src_req ? idx : '0;
  assign wr_addr = !wr_req ? '0 : state == DONE_WR ? ADDR_W'(FUSE_DONE_ADDR) : ADDR_W'(FUSE_BASE_ADDR) + ADDR_W'({idx, 2'b00});
  assign wr_data = !wr_req ? '0 : state == DONE_WR ? 32'h1 : data;
  assign load_busy = state inside {FETCH, WRITE, DONE_WR};
  assign load_done = state == DONE;
  assign load_err = state == ERROR;
  assign req = src_req || wr_req;
  assign ack = (src_req && src_ack) || (wr_req && wr_ack);
  assign hs_err = wr_req && wr_ack && wr_err;
  assign last = idx == IDX_W'(NUM_FUSE_WORDS - 1);
  soc_ifc_hs_timeout #(.LIMIT(ACK_TIMEOUT)) u_timeout (
    .clk(clk),
    .cptra_rst_b(cptra_rst_b),
    .clr(!req),
    .inc(req && !ack),
    .expire(expire)
  );
  always_comb begin
    state_n = state;
    idx_n = idx;
    data_n = data;
    err_n = err_idx;
    case (state)
      IDLE: if (ready_for_fuses) begin
        state_n = FETCH;
        idx_n = '0;
      end
      FETCH, WRITE, DONE_WR:
        if (gap) state_n = ready_for_fuses ? state : IDLE;
        else if (hs_err || (expire && ready_for_fuses)) begin
          state_n = ERROR;
          err_n = state == DONE_WR ? ERR_W'(NUM_FUSE_WORDS) : ERR_W'(idx);
        end
        else if (expire || (ack && !ready_for_fuses)) state_n = IDLE;
        else if (ack) begin
          state_n = state == FETCH ? WRITE : state == DONE_WR ? DONE : last ? DONE_WR : FETCH;
          data_n = state == FETCH ? src_data : data;
          idx_n = state == WRITE && !last ? idx + IDX_W'(1) : idx;
        end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge cptra_rst_b)
    if (!cptra_rst_b) begin
      state <= IDLE;
      gap <= 1'b0;
      idx <= '0;
      data <= '0;
      err_idx <= '0;
    end else begin
      state <= state_n;
      gap <= state_n != state;
      idx <= idx_n;
      data <= data_n;
      err_idx <= err_n;
    end
  assert property (@(posedge clk) disable iff (!cptra_rst_b)
    !$isunknown({state, src_req, src_idx, wr_req, wr_addr, wr_data, load_busy, load_done, load_err, err_idx}));
  assert property (@(posedge clk) disable iff (!cptra_rst_b)
    src_req && !src_ack && !expire |=> src_req && $stable(src_idx));
  assert property (@(posedge clk) disable iff (!cptra_rst_b)
    wr_req && !wr_ack && !expire |=> wr_req && $stable(wr_addr) && $stable(wr_data));
  assert property (@(posedge clk) disable iff (!cptra_rst_b) !(load_done && load_err));
endmodule

// File: tb/tb_soc_ifc_fuse_loader.sv
// tb_soc_ifc_fuse_loader: directed scoreboard bench for the fuse loader with N=4 and a 16-cycle timeout
module tb_soc_ifc_fuse_loader;
  localparam int N = 4;
  typedef struct {logic [17:0] a; logic [31:0] d;} wr_t;
  logic clk = 1'b0, cptra_rst_b = 1'b1, ready_for_fuses = 1'b0;
  logic src_ack = 1'b0, wr_ack = 1'b0, wr_err = 1'b0;
  logic [31:0] src_data = '0;
  logic src_req, wr_req, load_busy, load_done, load_err;
  logic [1:0] src_idx;
  logic [17:0] wr_addr;
  logic [31:0] wr_data;
  logic [2:0] err_idx;
  int errors = 0, checks = 0;
  int src_mode = 0, wr_mode = 0;
  logic [17:0] err_addr = '1;
  wr_t exp_q[$];
  soc_ifc_fuse_loader #(.NUM_FUSE_WORDS(N), .ACK_TIMEOUT(16)) dut (
    .clk(clk),
    .cptra_rst_b(cptra_rst_b),
    .ready_for_fuses(ready_for_fuses),
    .src_req(src_req),
    .src_idx(src_idx),
    .src_ack(src_ack),
    .src_data(src_data),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack(wr_ack),
    .wr_err(wr_err),
    .load_busy(load_busy),
    .load_done(load_done),
    .load_err(load_err),
    .err_idx(err_idx)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_all();
    for (int i = 0; i < N; i++) exp_q.push_back('{a: 18'h200 + 18'(4 * i), d: 32'hA0 + 32'(i)});
    exp_q.push_back('{a: 18'h3F8, d: 32'h1});
  endtask
  task automatic do_reset();
    @(negedge clk);
    cptra_rst_b = 1'b0;
    repeat (2) @(negedge clk);
    cptra_rst_b = 1'b1;
  endtask
  initial begin
    int cnt, dly;
    cnt = 0;
    dly = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!src_req) begin
        src_ack = 1'b0;
        cnt = 0;
        dly = src_mode == 1 ? int'($urandom_range(10)) : src_mode == 3 ? 3 : 0;
      end else begin
        src_ack = src_mode != 2 && cnt == dly;
        src_data = 32'(src_idx) + 32'hA0;
        cnt++;
      end
    end
  end
  initial begin
    int cnt, dly;
    cnt = 0;
    dly = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!wr_req) begin
        wr_ack = 1'b0;
        wr_err = 1'b0;
        cnt = 0;
        dly = wr_mode == 1 ? int'($urandom_range(10)) : wr_mode == 3 ? 3 : 0;
      end else begin
        wr_ack = cnt == dly;
        wr_err = cnt == dly && wr_addr == err_addr;
        cnt++;
      end
    end
  end
  initial begin
    logic pv_s, pa_s, pv_w, pa_w;
    logic [1:0] pidx;
    logic [17:0] paddr;
    logic [31:0] pdata;
    wr_t e;
    pv_s = 0; pa_s = 0; pv_w = 0; pa_w = 0;
    pidx = '0; paddr = '0; pdata = '0;
    forever begin
      @(negedge clk);
      if (pv_s && !pa_s && cptra_rst_b && !load_err) chk("src_stable", {src_req, src_idx}, {1'b1, pidx});
      if (pv_w && !pa_w && cptra_rst_b && !load_err) chk("wr_stable", {wr_req, wr_addr, wr_data}, {1'b1, paddr, pdata});
      if (wr_req && wr_ack && !wr_err) begin
        chk("wr_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.a);
          chk("wr_data", wr_data, e.d);
        end
      end
      pv_s = src_req; pa_s = src_ack; pidx = src_idx;
      pv_w = wr_req; pa_w = wr_ack; paddr = wr_addr; pdata = wr_data;
    end
  end
  initial begin
    int n, seen;
    #1 cptra_rst_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {src_req, src_idx, wr_req, wr_addr, wr_data, load_busy, load_done, load_err, err_idx}, 0);
    push_all();
    cptra_rst_b = 1'b1;
    ready_for_fuses = 1'b1;
    n = 0;
    while (!load_done && n < 200) begin @(negedge clk); n++; end
    chk("zw_done_latency", n, 19);
    chk("zw_busy", load_busy, 0);
    chk("zw_err", load_err, 0);
    chk("zw_queue_empty", exp_q.size(), 0);
    ready_for_fuses = 1'b0;
    repeat (5) @(negedge clk);
    chk("done_sticky", {load_done, load_busy, wr_req}, 3'b100);
    src_mode = 1; wr_mode = 1;
    ready_for_fuses = 1'b1;
    push_all();
    do_reset();
    n = 0;
    while (!load_done && n < 1000) begin @(negedge clk); n++; end
    chk("rnd_done", load_done, 1);
    chk("rnd_queue_empty", exp_q.size(), 0);
    src_mode = 0; wr_mode = 0; err_addr = 18'h208;
    exp_q.push_back('{a: 18'h200, d: 32'hA0});
    exp_q.push_back('{a: 18'h204, d: 32'hA1});
    do_reset();
    n = 0;
    while (!load_err && n < 200) begin @(negedge clk); n++; end
    chk("werr_load_err", load_err, 1);
    chk("werr_err_idx", err_idx, 2);
    seen = 0;
    repeat (20) begin @(negedge clk); seen |= int'(wr_req); end
    chk("werr_no_more_wr", seen, 0);
    chk("werr_not_done", load_done, 0);
    chk("werr_queue_empty", exp_q.size(), 0);
    err_addr = '1; src_mode = 2;
    do_reset();
    n = 0;
    while (!src_req && n < 50) begin @(negedge clk); n++; end
    chk("to_src_req_rise", src_req, 1);
    n = 0;
    while (!load_err && n < 100) begin @(negedge clk); n++; end
    chk("to_latency", n, 16);
    chk("to_err_idx", err_idx, 0);
    chk("to_req_dropped", {src_req, load_busy}, 0);
    src_mode = 0; wr_mode = 3;
    exp_q.push_back('{a: 18'h200, d: 32'hA0});
    exp_q.push_back('{a: 18'h204, d: 32'hA1});
    do_reset();
    n = 0;
    while (!(wr_req && wr_addr == 18'h204) && n < 100) begin @(negedge clk); n++; end
    chk("rdy_word1_wr", {wr_req, wr_addr}, {1'b1, 18'h204});
    ready_for_fuses = 1'b0;
    n = 0;
    while (load_busy && n < 50) begin @(negedge clk); n++; end
    chk("rdy_idle", {load_busy, load_done, load_err}, 0);
    chk("rdy_word1_done", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    push_all();
    ready_for_fuses = 1'b1;
    n = 0;
    while (!load_done && n < 500) begin @(negedge clk); n++; end
    chk("rdy_restart_done", load_done, 1);
    chk("rdy_restart_queue", exp_q.size(), 0);
    exp_q.push_back('{a: 18'h200, d: 32'hA0});
    do_reset();
    n = 0;
    while (!(wr_req && wr_addr == 18'h204) && n < 100) begin @(negedge clk); n++; end
    chk("arst_word1_wr", {wr_req, wr_addr}, {1'b1, 18'h204});
    #2 cptra_rst_b = 1'b0;
    #1 chk("arst_outputs", {src_req, src_idx, wr_req, wr_addr, wr_data, load_busy, load_done, load_err, err_idx}, 0);
    repeat (2) @(negedge clk);
    chk("arst_queue", exp_q.size(), 0);
    push_all();
    cptra_rst_b = 1'b1;
    n = 0;
    while (!load_done && n < 500) begin @(negedge clk); n++; end
    chk("arst_redo_done", load_done, 1);
    chk("arst_redo_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
